// File: rtl/round_robin_arbiter_if.sv
// Request/grant bundle between requesters (master) and the round-robin arbiter (slave).
// release_gnt: the current grantee is finished with the shared resource.
interface round_robin_arbiter_if;
    logic [3:0] req;
    logic       release_gnt;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic       timeout;

    modport master (
        output req,
        output release_gnt,
        input  gnt,
        input  gnt_valid,
        input  timeout
    );

    modport slave (
        input  req,
        input  release_gnt,
        output gnt,
        output gnt_valid,
        output timeout
    );
endinterface

// File: rtl/round_robin_arbiter.sv
// Four-way round-robin arbiter with a one-hot registered grant and a bounded hold time.
// Each grant is separated by at least one idle cycle.
module round_robin_arbiter #(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    round_robin_arbiter_if.slave bus
);
    localparam int unsigned N  = 4;
    localparam int unsigned PW = 2;
    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] HCNT_LAST = CW'(HOLD_MAX - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         state;
    state_t         state_next;
    logic [N-1:0]   gnt;
    logic [N-1:0]   gnt_next;
    logic           gnt_valid;
    logic           timeout;
    logic           timeout_next;
    logic [PW-1:0]  ptr;
    logic [PW-1:0]  ptr_next;
    logic [CW-1:0]  hcnt;
    logic [CW-1:0]  hcnt_next;
    logic [PW-1:0]  cand;
    logic [PW-1:0]  pick_idx;
    logic           pick_found;
    logic [PW-1:0]  gnt_idx;
    logic           exit_rel;
    logic           exit_hold;

    // State register plus all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            ptr       <= '0;
            hcnt      <= '0;
        end else begin
            state     <= state_next;
            gnt       <= gnt_next;
            gnt_valid <= |gnt_next;
            timeout   <= timeout_next;
            ptr       <= ptr_next;
            hcnt      <= hcnt_next;
        end
    end

    // First requester at or after ptr; descending scan so the lowest offset wins
    always_comb begin
        cand       = '0;
        pick_idx   = '0;
        pick_found = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = ptr + PW'(k);
            if (bus.req[cand]) begin
                pick_idx   = cand;
                pick_found = 1'b1;
            end
        end
    end

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) gnt_idx = PW'(i);
        end
    end

    // Normal release (explicit or dropped request) outranks the hold limit
    assign exit_rel  = bus.release_gnt | ~|(bus.req & gnt);
    assign exit_hold = (hcnt == HCNT_LAST);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (pick_found)            state_next = GRANT;
            GRANT: if (exit_rel || exit_hold) state_next = IDLE;
        endcase
    end

    always_comb begin
        gnt_next     = gnt;
        ptr_next     = ptr;
        hcnt_next    = hcnt;
        timeout_next = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    gnt_next  = N'(1) << pick_idx;
                    hcnt_next = '0;
                end
            end
            GRANT: begin
                if (exit_rel || exit_hold) begin
                    gnt_next     = '0;
                    ptr_next     = gnt_idx + PW'(1);
                    hcnt_next    = '0;
                    timeout_next = exit_hold & ~exit_rel;
                end else begin
                    hcnt_next = hcnt + CW'(1);
                end
            end
        endcase
    end

    assign bus.gnt       = gnt;
    assign bus.gnt_valid = gnt_valid;
    assign bus.timeout   = timeout;
endmodule

// File: tb/tb_round_robin_arbiter.sv
// Bench for round_robin_arbiter: HOLD_MAX=4 and HOLD_MAX=1 instances share stimulus,
// a transaction-level model feeds a scoreboard, and directed tasks check key scenarios.
module tb_round_robin_arbiter;
    bit clk;
    always #5 clk = ~clk;

    logic [3:0] req_s = '0;
    logic       rel_s = 1'b0;
    logic       rst_s = 1'b1;

    int checks = 0;
    int errors = 0;

    round_robin_arbiter_if bus4();
    round_robin_arbiter_if bus1();
    assign bus4.req = req_s;
    assign bus4.release_gnt = rel_s;
    assign bus1.req = req_s;
    assign bus1.release_gnt = rel_s;

    round_robin_arbiter #(.HOLD_MAX(4)) dut4 (.clk(clk), .rst(rst_s), .bus(bus4));
    round_robin_arbiter #(.HOLD_MAX(1)) dut1 (.clk(clk), .rst(rst_s), .bus(bus1));

    typedef struct {
        logic [3:0] gnt;
        logic       tmo;
        int         idx;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    // Model: owner index (-1 idle), next-priority pointer, cycles the current grant has been shown
    int  m_owner[2] = '{-1, -1};
    int  m_ptr[2]   = '{0, 0};
    int  m_age[2]   = '{0, 0};
    bit  m_tmo[2]   = '{0, 0};
    int  hold[2]    = '{4, 1};
    int  m_c;
    bit  m_done;
    exp_t m_e;

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst_s) begin
                m_owner[d] = -1;
                m_ptr[d]   = 0;
                m_age[d]   = 0;
                m_tmo[d]   = 0;
            end else if (m_owner[d] < 0) begin
                m_tmo[d] = 0;
                for (int k = 0; k < 4; k++) begin
                    m_c = (m_ptr[d] + k) % 4;
                    if (req_s[m_c] && m_owner[d] < 0) begin
                        m_owner[d] = m_c;
                        m_age[d]   = 1;
                    end
                end
            end else begin
                m_done = rel_s || !req_s[m_owner[d]];
                if (m_done || m_age[d] == hold[d]) begin
                    m_tmo[d]   = !m_done;
                    m_ptr[d]   = (m_owner[d] + 1) % 4;
                    m_owner[d] = -1;
                end else begin
                    m_age[d] = m_age[d] + 1;
                    m_tmo[d] = 0;
                end
            end
            m_e.gnt = (m_owner[d] < 0) ? 4'b0000 : (4'(1) << m_owner[d]);
            m_e.tmo = m_tmo[d];
            m_e.idx = m_owner[d];
            if (d == 0) q0.push_back(m_e);
            else        q1.push_back(m_e);
        end
    end

    function automatic logic [1:0] encode4(input logic [3:0] v);
        logic [1:0] y = 2'd0;
        for (int i = 0; i < 4; i++) if (v[i]) y = 2'(i);
        return y;
    endfunction

    logic [3:0] o_gnt[2];
    logic       o_val[2];
    logic       o_tmo[2];
    assign o_gnt[0] = bus4.gnt;
    assign o_gnt[1] = bus1.gnt;
    assign o_val[0] = bus4.gnt_valid;
    assign o_val[1] = bus1.gnt_valid;
    assign o_tmo[0] = bus4.timeout;
    assign o_tmo[1] = bus1.timeout;

    exp_t s_e;
    bit   s_have;

    // Scoreboard: pop the model's prediction for the edge just taken and compare
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            s_have = 0;
            if (d == 0 && q0.size() > 0) begin s_e = q0.pop_front(); s_have = 1; end
            if (d == 1 && q1.size() > 0) begin s_e = q1.pop_front(); s_have = 1; end
            if (s_have) begin
                checks++;
                if (o_gnt[d] !== s_e.gnt) begin
                    errors++;
                    $display("FAIL sb_gnt dut%0d t=%0t: got %b expected %b", d, $time, o_gnt[d], s_e.gnt);
                end
                checks++;
                if (o_tmo[d] !== s_e.tmo) begin
                    errors++;
                    $display("FAIL sb_timeout dut%0d t=%0t: got %b expected %b", d, $time, o_tmo[d], s_e.tmo);
                end
                checks++;
                if (o_val[d] !== (s_e.gnt != 4'b0000)) begin
                    errors++;
                    $display("FAIL sb_gnt_valid dut%0d t=%0t: got %b expected %b", d, $time, o_val[d], s_e.gnt != 4'b0000);
                end
                checks++;
                if ($countones(o_gnt[d]) > 1 || o_val[d] !== (|o_gnt[d])) begin
                    errors++;
                    $display("FAIL sb_onehot dut%0d t=%0t: gnt %b valid %b", d, $time, o_gnt[d], o_val[d]);
                end
                if (o_val[d] === 1'b1 && s_e.idx >= 0) begin
                    checks++;
                    if (encode4(o_gnt[d]) !== 2'(s_e.idx)) begin
                        errors++;
                        $display("FAIL sb_encoder dut%0d t=%0t: got %0d expected %0d", d, $time, encode4(o_gnt[d]), s_e.idx);
                    end
                end
            end
        end
    end

    // Apply inputs at a falling edge and return at the next falling edge (outputs settled)
    task automatic tick(input logic [3:0] r, input logic rl, input logic rs);
        req_s = r;
        rel_s = rl;
        rst_s = rs;
        @(negedge clk);
    endtask

    task automatic test_reset();
        tick(4'b1111, 1'b1, 1'b1);
        checks++;
        if (bus4.gnt !== 4'b0000 || bus4.gnt_valid !== 1'b0 || bus4.timeout !== 1'b0 || dut4.ptr !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: gnt %b valid %b timeout %b ptr %0d, expected 0000 0 0 0",
                     bus4.gnt, bus4.gnt_valid, bus4.timeout, dut4.ptr);
        end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_seq [9] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                                    4'b0000, 4'b1000, 4'b0000, 4'b0001};
        tick(4'b0000, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            tick(4'b1111, 1'(i % 2), 1'b0);
            checks++;
            if (bus4.gnt !== exp_seq[i]) begin
                errors++;
                $display("FAIL rotation step %0d: got %b expected %b", i, bus4.gnt, exp_seq[i]);
            end
        end
    endtask

    task automatic test_ptr_wrap();
        tick(4'b0000, 1'b0, 1'b1);
        tick(4'b0010, 1'b0, 1'b0);
        tick(4'b0010, 1'b1, 1'b0);
        checks++;
        if (dut4.ptr !== 2'd2) begin
            errors++;
            $display("FAIL ptr_setup: got %0d expected 2", dut4.ptr);
        end
        tick(4'b0011, 1'b0, 1'b0);
        checks++;
        if (bus4.gnt !== 4'b0001) begin
            errors++;
            $display("FAIL ptr_wrap_gnt: got %b expected 0001", bus4.gnt);
        end
        tick(4'b0011, 1'b1, 1'b0);
        checks++;
        if (dut4.ptr !== 2'd1) begin
            errors++;
            $display("FAIL ptr_after_wrap: got %0d expected 1", dut4.ptr);
        end
    endtask

    task automatic test_timeout();
        tick(4'b0000, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick(4'b0100, 1'b0, 1'b0);
            checks++;
            if (bus4.gnt !== 4'b0100 || bus4.timeout !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle %0d: gnt %b timeout %b expected 0100 0", i, bus4.gnt, bus4.timeout);
            end
        end
        tick(4'b0100, 1'b0, 1'b0);
        checks++;
        if (bus4.gnt !== 4'b0000 || bus4.timeout !== 1'b1 || dut4.ptr !== 2'd3) begin
            errors++;
            $display("FAIL timeout_exit: gnt %b timeout %b ptr %0d expected 0000 1 3", bus4.gnt, bus4.timeout, dut4.ptr);
        end
        tick(4'b0100, 1'b0, 1'b0);
        checks++;
        if (bus4.gnt !== 4'b0100 || bus4.timeout !== 1'b0) begin
            errors++;
            $display("FAIL regrant_after_timeout: gnt %b timeout %b expected 0100 0", bus4.gnt, bus4.timeout);
        end
    endtask

    task automatic test_release_at_limit();
        tick(4'b0000, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) tick(4'b0100, 1'b0, 1'b0);
        tick(4'b0100, 1'b1, 1'b0);
        checks++;
        if (bus4.gnt !== 4'b0000 || bus4.timeout !== 1'b0) begin
            errors++;
            $display("FAIL release_at_limit: gnt %b timeout %b expected 0000 0", bus4.gnt, bus4.timeout);
        end
    endtask

    task automatic test_reset_mid_grant();
        tick(4'b0000, 1'b0, 1'b1);
        tick(4'b1000, 1'b0, 1'b0);
        checks++;
        if (bus4.gnt !== 4'b1000) begin
            errors++;
            $display("FAIL mid_grant_setup: got %b expected 1000", bus4.gnt);
        end
        tick(4'b1000, 1'b0, 1'b1);
        checks++;
        if (bus4.gnt !== 4'b0000 || dut4.ptr !== 2'd0 || bus4.timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_grant: gnt %b ptr %0d timeout %b expected 0000 0 0", bus4.gnt, dut4.ptr, bus4.timeout);
        end
        tick(4'b1010, 1'b0, 1'b0);
        checks++;
        if (bus4.gnt !== 4'b0010) begin
            errors++;
            $display("FAIL post_reset_grant: got %b expected 0010", bus4.gnt);
        end
    endtask

    task automatic test_random();
        logic [3:0] r = 4'b0000;
        tick(4'b0000, 1'b0, 1'b1);
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom);
            tick(r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) == 0));
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_rotation();
        test_ptr_wrap();
        test_timeout();
        test_release_at_limit();
        test_reset_mid_grant();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/round_robin_arbiter.md
ROUND_ROBIN_ARBITER -- requirements
Module: round_robin_arbiter

Interface
REQ-001 The block SHALL have parameter HOLD_MAX, default 16, meaning the maximum number of cycles one grant may be held (legal range 1..255).
REQ-002 The block SHALL have port clk  input  1  the single clock, all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port req  input  4  request lines; bit i is requester i.
REQ-005 The block SHALL have port release  input  1  the current grantee is finished; sampled only in GRANT.
REQ-006 The block SHALL have port gnt  output  4  registered one-hot grant that drives the downstream 4-to-2 encoder inputs Y3..Y0 (bit i to Yi).
REQ-007 The block SHALL have port gnt_valid  output  1  high exactly when gnt is non-zero.
REQ-008 The block SHALL have port timeout  output  1  one-cycle pulse when a grant is force-released by HOLD_MAX.

Function
REQ-009 The block SHALL implement a two-state FSM, IDLE and GRANT, plus a 2-bit priority pointer ptr and an 8-bit hold counter hcnt.
REQ-010 In IDLE with req==0, state, gnt, ptr and hcnt SHALL remain unchanged (gnt=0).
REQ-011 In IDLE with req!=0, the next edge SHALL select the first set bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4), load gnt with that one-hot value, clear hcnt to 0 and enter GRANT.
REQ-012 Grant latency SHALL be one cycle: a request sampled at edge N appears on gnt after edge N.
REQ-013 gnt SHALL never have more than one bit set, under any input sequence.
REQ-014 In GRANT, gnt SHALL be held constant, and hcnt SHALL increment by 1 per cycle.
REQ-015 In GRANT, the exit condition SHALL be any of: release==1; the granted req bit ==0; or hcnt==HOLD_MAX-1.
REQ-016 On exit, the next edge SHALL clear gnt to 0, enter IDLE and set ptr to (granted index + 1) mod 4.
REQ-017 At least one IDLE cycle (gnt==0) SHALL therefore separate any two grants.
REQ-018 timeout SHALL pulse high for the one cycle after the exiting edge only when the exit was caused solely by hcnt==HOLD_MAX-1.
REQ-019 If release or a dropped req coincides with hcnt==HOLD_MAX-1, timeout SHALL stay low, because normal release has priority.
REQ-020 With HOLD_MAX=1, every grant SHALL last exactly one cycle and SHALL assert timeout unless released in that cycle.
REQ-021 Changes on req while in GRANT SHALL have no effect, except the granted bit dropping.
REQ-022 The ptr wrap SHALL follow the sequence 3 -> 0.
REQ-023 Arithmetic on ptr SHALL be modulo 4, and hcnt SHALL never exceed HOLD_MAX-1.

Reset
REQ-024 While rst==1 at an edge, the block SHALL force state=IDLE, ptr=0, hcnt=0, gnt=4'b0000, gnt_valid=0 and timeout=0, regardless of other inputs.
REQ-025 A reset asserted mid-GRANT SHALL drop gnt to 0 at that edge, with no timeout pulse, and SHALL not advance ptr.
REQ-026 In the first cycle after rst deasserts, the block SHALL arbitrate from ptr=0.

Verification
REQ-027 Reset, then req=4'b1111 held with release pulsed one cycle into each grant SHALL produce the gnt sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001.
REQ-028 With ptr=2, req=4'b0011 SHALL produce gnt=4'b0001 and then ptr=1.
REQ-029 HOLD_MAX=4 with req=4'b0100 held and no release SHALL hold gnt=0100 for 4 cycles, then give gnt=0 with timeout=1 for one cycle, then re-grant 0100 once ptr=3 scans around.
REQ-030 Release asserted in the same cycle as hcnt==HOLD_MAX-1 SHALL exit with timeout=0.
REQ-031 rst asserted during a grant of 1000 SHALL give gnt=0 and ptr=0 on the next cycle; after deassert, req=4'b1010 SHALL be granted 0010.
REQ-032 A random req/release/rst run of at least 10k cycles SHALL confirm that gnt is one-hot-or-zero, gnt_valid==|gnt, and the encoder output equals log2(gnt) whenever gnt_valid is high.
